// File: rtl/serial_mag_comp_pkg.sv
// Shared types and default sizing for the serial magnitude comparator.
// Used by serial_mag_comp and digit_cmp.
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_res_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/serial_mag_comp_digit_cmp.sv
// Combinational DIGIT-bit slice comparator: equality and unsigned greater-than.
module digit_cmp #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             d_eq,
  output logic             d_gt
);

  assign d_eq = &(x ~^ y);
  assign d_gt = (x > y);

endmodule

// File: rtl/serial_mag_comp.sv
// Serial magnitude comparator, one DIGIT-bit slice per clock, MSB slice first.
// Define SERIAL_MAG_COMP_SIGNED_EN for two's-complement operands.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | comparing slice idx, stops at first differing slice
// FIN   | done pulse; start here is accepted back-to-back
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    idx;
  logic [DIGIT-1:0] sa, sb;
  logic             d_eq, d_gt;
  cmp_res_t         res;

  always_comb begin
    sa = a_r[int'(idx) * DIGIT +: DIGIT];
    sb = b_r[int'(idx) * DIGIT +: DIGIT];
`ifdef SERIAL_MAG_COMP_SIGNED_EN
    // flipping both sign bits maps two's complement onto unsigned ordering
    if (idx == IDX_TOP) begin
      sa[DIGIT-1] = ~sa[DIGIT-1];
      sb[DIGIT-1] = ~sb[DIGIT-1];
    end
`else
`endif
  end

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .x    (sa),
    .y    (sb),
    .d_eq (d_eq),
    .d_gt (d_gt)
  );

  always_comb begin
    res = EQ;
    if (!d_eq) res = d_gt ? GT : LT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            idx   <= IDX_TOP;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (res != EQ || idx == '0) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            eq    <= (res == EQ);
            gt    <= (res == GT);
            lt    <= (res == LT);
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
